inst_store: RTL
===============

# inst_store

Loadable 8-entry instruction store that answers the processor's instruction fetch: the processor drives `address`, and this block returns the 16-bit `instruction` word. A valid/ready load port fills the store sequentially from a host or debug source. Unloaded slots, and every fetch during loading, return 0x0000, which the processor decodes as NOP. The block sits between the program-load path and the processor's `address`/`instruction` pins.

## Interface
- `DEPTH`, 8: number of instruction words; a power of two.
- `ADDR_W`, 3: fetch address width, log2(DEPTH).
- `DATA_W`, 16: instruction width.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_start`  in  1  single-cycle pulse; clears the store and begins a new load.
- `load_valid`  in  1  `load_data` is valid.
- `load_data`  in  DATA_W  instruction word to append.
- `load_ready`  out  1  store accepts a word this cycle.
- `load_end`  in  1  terminates the load early; sampled only in LOAD.
- `address`  in  ADDR_W  fetch address from the processor.
- `instruction`  out  DATA_W  registered fetch result.
- `loaded`  out  1  program present; fetches are live.
- `load_count`  out  ADDR_W+1  number of words currently stored (0..DEPTH).

## Operation
- FSM states: IDLE, LOAD, RUN. On reset the FSM enters IDLE.
- Reset values:
  - all memory words = 0x0000
  - `wr_ptr` = 0
  - `load_count` = 0
  - `instruction` = 0x0000
  - `load_ready` = 0
  - `loaded` = 0
- IDLE:
  - `instruction` is driven 0x0000.
  - `load_start` causes the transition to LOAD.
- `load_start`, in any state (IDLE, LOAD, RUN):
  - clears all DEPTH words to 0x0000 in one cycle;
  - sets `wr_ptr` = 0 and `load_count` = 0;
  - next state is LOAD.
- LOAD:
  - `load_ready` = 1.
  - Accept = `load_valid` & `load_ready`. On accept: mem[`wr_ptr`] <= `load_data`, `wr_ptr`++, `load_count`++.
  - The accept that brings `load_count` to DEPTH moves the FSM to RUN.
  - `load_end` moves the FSM to RUN. If an accept happens in the same cycle, that word is written first.
  - `load_end` with `load_count` = 0 and no accept returns the FSM to IDLE (empty program).
  - `instruction` is driven 0x0000 throughout LOAD.
- RUN:
  - `loaded` = 1; `load_ready` = 0.
  - Each cycle `instruction` <= (`address` < `load_count`) ? mem[`address`] : 0x0000.
  - `load_valid` is ignored.
- Simultaneous `load_start` and accept in LOAD: `load_start` wins, the word is discarded, and the store restarts empty.
- `load_end` outside LOAD is ignored.
- Width rules:
  - `wr_ptr` is ADDR_W bits and never wraps; the FSM leaves LOAD on the DEPTH-th accept.
  - `load_count` is ADDR_W+1 bits so that DEPTH is representable.
  - The comparison `address` < `load_count` is unsigned and zero-extends `address`.

## Timing
- `load_ready`, `loaded` and `load_count` are Moore outputs decoded from registered state; none is combinational from inputs.
- Fetch latency: 1 cycle. `address` sampled at edge N appears on `instruction` after edge N.
- The first valid fetch result follows the first RUN-state edge, i.e. two edges after the final accept or `load_end`.
- Load throughput: one word per cycle while `load_valid` is held high.
- The upstream source may hold `load_valid` high with stable data; the word transfers on the first edge where `load_ready` = 1.
- `rst` has priority over `load_start`.
- `rst` asserted mid-load returns the block to its reset state on the next edge; partial contents are lost.

## Structure
- Shared package `proc_pkg`:
  - `ADDR_W`, `DATA_W` and `DEPTH` constants, shared with `processor`;
  - the FSM state enum {IDLE, LOAD, RUN};
  - `OP_NOP` = 4'b0000 and `NOP_WORD` = 16'h0000.
- One sub-module is natural: `inst_mem`, a DEPTH×DATA_W register array with:
  - a synchronous clear-all,
  - one write port,
  - one registered read port with a read-enable and a zero-force input.
- The FSM, pointer and counter live in `inst_store`.

## Test plan
- Reset, then hold `address`=3 → `instruction`=0x0000, `loaded`=0, `load_ready`=0, `load_count`=0.
- Load full program: pulse `load_start`, stream 8 words 0x1101,0x1202,…,0x1808 with `load_valid` held → 8 accepts on consecutive cycles, `load_ready` drops after the 8th, `loaded`=1. Sweep `address` 0..7 → each word returned one cycle after its address.
- Early end: load 0x1105, 0x2240, then pulse `load_end` together with the second accept → `load_count`=2, RUN. `address`=1 → 0x2240; `address`=5 → 0x0000.
- Backpressure and gaps: toggle `load_valid` 1,0,0,1 with data 0xAAAA,—,—,0xBBBB → exactly 2 writes, at mem[0] and mem[1]; `load_count`=2.
- Reload collision: in LOAD with `load_count`=4, assert `load_start` and `load_valid` (0xDEAD) in the same cycle → `load_count`=0, no entry equals 0xDEAD, state LOAD.
- Reset mid-load: after 5 accepts, assert `rst` for 1 cycle → next cycle all outputs at reset values; `address`=0 → 0x0000.

Source files
------------

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Constants and types shared by the processor and its instruction store.
//   DEPTH / ADDR_W / DATA_W : store geometry (DEPTH is a power of two)
//   state_t                 : instruction-store load FSM states
//   OP_NOP / NOP_WORD       : the opcode and full word decoded as "no operation"
// -----------------------------------------------------------------------------
package proc_pkg;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [3:0]        OP_NOP   = 4'b0000;
   localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;

endpackage : proc_pkg

// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem
// DEPTH x DATA_W register array with a synchronous clear-all, one write port
// and one registered read port.
//   i_clk      : clock
//   i_clear    : clears every word and the read register on the next edge
//   i_wr_en    : write i_wr_data into word i_wr_addr
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : update the read register this cycle (otherwise it holds)
//   i_rd_zero  : when reading, return NOP_WORD instead of the stored word
//   i_rd_addr  : read address
//   o_rd_data  : registered read data
// -----------------------------------------------------------------------------
module inst_mem
   import proc_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_clear,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic              i_rd_zero,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   // NOTE: the array is built from flops rather than a RAM macro precisely
   // because every word must be cleared in a single cycle; that is what
   // makes resetting a memory legitimate here.
   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= NOP_WORD;
         end
         r_rd_data <= NOP_WORD;
      end else begin
         if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
         end
         if (i_rd_en) begin
            r_rd_data <= i_rd_zero ? NOP_WORD : r_mem[i_rd_addr];
         end
      end
   end

   assign o_rd_data = r_rd_data;

endmodule : inst_mem

// File: rtl/inst_store.sv
// -----------------------------------------------------------------------------
// inst_store
// Loadable instruction store answering the processor's instruction fetch.
// A valid/ready port fills the store sequentially; unloaded slots and every
// fetch outside RUN return NOP_WORD.
//   i_clk          : clock, all state changes on the rising edge
//   i_rst          : synchronous active-high reset (priority over load start)
//   i_load_start   : pulse; clears the store and begins a new load
//   i_load_valid   : i_load_data is valid
//   i_load_data    : instruction word to append
//   o_load_ready   : store accepts a word this cycle (LOAD state)
//   i_load_end     : ends the load early; only looked at in LOAD
//   i_address      : fetch address
//   o_instruction  : registered fetch result, one cycle latency
//   o_loaded       : a program is present and fetches are live (RUN state)
//   o_load_count   : number of words currently stored, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_store
   import proc_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_start,
   input  logic              i_load_valid,
   input  logic [DATA_W-1:0] i_load_data,
   output logic              o_load_ready,
   input  logic              i_load_end,
   input  logic [ADDR_W-1:0] i_address,
   output logic [DATA_W-1:0] o_instruction,
   output logic              o_loaded,
   output logic [ADDR_W:0]   o_load_count
);

   localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_load_count;

   logic w_load_ready;
   logic w_accept;
   logic w_in_range;
   logic w_clear;

   assign w_load_ready = (r_state == LOAD);

   // A load start in the same cycle as an accept discards the word.
   assign w_accept = i_load_valid & w_load_ready & ~i_load_start;

   // Unsigned compare with the fetch address zero-extended to the count width.
   assign w_in_range = ({1'b0, i_address} < r_load_count);

   assign w_clear = i_rst | i_load_start;

   // NOTE: every signal assigned in always_comb gets a default on the first
   // line, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      if (i_load_start) begin
         w_next_state = LOAD;
      end else begin
         case (r_state)
            IDLE: w_next_state = IDLE;
            LOAD: begin
               if (w_accept && (r_load_count == LAST_COUNT)) begin
                  w_next_state = RUN;
               end else if (i_load_end) begin
                  // An early end with nothing stored means an empty program.
                  w_next_state = (w_accept || (r_load_count != '0)) ? RUN : IDLE;
               end
            end
            RUN:     w_next_state = RUN;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled before the edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_wr_ptr     <= '0;
         r_load_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (i_load_start) begin
            r_wr_ptr     <= '0;
            r_load_count <= '0;
         end else if (w_accept) begin
            // The FSM leaves LOAD on the DEPTH-th accept, so the pointer
            // rolling to zero at that point is never used for a write.
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_load_count <= r_load_count + 1'b1;
         end
      end
   end

   // The read register is only updated in RUN. IDLE and LOAD are entered
   // solely through reset or a clear (or LOAD->IDLE with nothing stored),
   // all of which leave it at NOP_WORD.
   inst_mem u_inst_mem (
      .i_clk     (i_clk),
      .i_clear   (w_clear),
      .i_wr_en   (w_accept),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_load_data),
      .i_rd_en   (r_state == RUN),
      .i_rd_zero (~w_in_range),
      .i_rd_addr (i_address),
      .o_rd_data (o_instruction)
   );

   assign o_load_ready = w_load_ready;
   assign o_loaded     = (r_state == RUN);
   assign o_load_count = r_load_count;

endmodule : inst_store
